// File: rtl/buffer_access_controller.sv
// Single-port image buffer shared by one writer and one reader stage through
// a request/acknowledge handshake; owns storage, circular pointers and fill level.
module buffer_access_controller #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 1024,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  rq_write,
    input  logic                  writing,
    output logic                  ack_write,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rq_read,
    input  logic                  reading,
    output logic                  ack_read,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  full,
    output logic                  empty,
    output logic                  wr_overflow,
    output logic                  rd_underflow
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT_W = 2'd1,
        ST_GRANT_R = 2'd2
    } state_t;

    localparam logic [ADDR_WIDTH:0]   CNT_ONE   = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH:0]   CNT_DEPTH = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE   = ADDR_WIDTH'(1);

    state_t                r_state;
    logic                  r_last_w;
    logic                  r_ack_write;
    logic                  r_ack_read;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [ADDR_WIDTH-1:0] r_wr_ptr;
    logic [ADDR_WIDTH-1:0] r_rd_ptr;
    logic [ADDR_WIDTH:0]   r_count;
    logic                  r_full;
    logic                  r_empty;
    logic [DATA_WIDTH-1:0] r_rd_data;
    logic                  r_rd_valid;
    logic                  r_wr_overflow;
    logic                  r_rd_underflow;

    logic w_wr_fire;
    logic w_rd_fire;
    logic w_wr_accept;
    logic w_rd_accept;

    // A strobe only counts while its side holds the grant and its busy level.
    assign w_wr_fire   = (r_state == ST_GRANT_W) && writing && wr_en;
    assign w_rd_fire   = (r_state == ST_GRANT_R) && reading && rd_en;
    assign w_wr_accept = w_wr_fire && !r_full;
    assign w_rd_accept = w_rd_fire && !r_empty;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_last_w    <= 1'b0;
            r_ack_write <= 1'b0;
            r_ack_read  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    // On a tie, the side not served last wins.
                    if (rq_write && (!rq_read || !r_last_w)) begin
                        r_state     <= ST_GRANT_W;
                        r_last_w    <= 1'b1;
                        r_ack_write <= 1'b1;
                    end else if (rq_read) begin
                        r_state    <= ST_GRANT_R;
                        r_last_w   <= 1'b0;
                        r_ack_read <= 1'b1;
                    end
                end
                ST_GRANT_W: begin
                    if (!rq_write && !writing) begin
                        r_state     <= ST_IDLE;
                        r_ack_write <= 1'b0;
                    end
                end
                ST_GRANT_R: begin
                    if (!rq_read && !reading) begin
                        r_state    <= ST_IDLE;
                        r_ack_read <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_ack_write <= 1'b0;
                    r_ack_read  <= 1'b0;
                end
            endcase
        end
    end

    // Storage is kept out of the reset domain so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (w_wr_accept) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr       <= '0;
            r_rd_ptr       <= '0;
            r_count        <= '0;
            r_full         <= 1'b0;
            r_empty        <= 1'b1;
            r_rd_data      <= '0;
            r_rd_valid     <= 1'b0;
            r_wr_overflow  <= 1'b0;
            r_rd_underflow <= 1'b0;
        end else begin
            r_rd_valid     <= 1'b0;
            r_wr_overflow  <= w_wr_fire && r_full;
            r_rd_underflow <= w_rd_fire && r_empty;
            // Grants are exclusive, so at most one of these fires per cycle.
            if (w_wr_accept) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
                r_count  <= r_count + CNT_ONE;
                r_full   <= (r_count == (CNT_DEPTH - CNT_ONE));
                r_empty  <= 1'b0;
            end else if (w_rd_accept) begin
                r_rd_data  <= r_mem[r_rd_ptr];
                r_rd_valid <= 1'b1;
                r_rd_ptr   <= r_rd_ptr + PTR_ONE;
                r_count    <= r_count - CNT_ONE;
                r_empty    <= (r_count == CNT_ONE);
                r_full     <= 1'b0;
            end
        end
    end

    assign ack_write    = r_ack_write;
    assign ack_read     = r_ack_read;
    assign rd_data      = r_rd_data;
    assign rd_valid     = r_rd_valid;
    assign count        = r_count;
    assign full         = r_full;
    assign empty        = r_empty;
    assign wr_overflow  = r_wr_overflow;
    assign rd_underflow = r_rd_underflow;

endmodule

// File: tb/tb_buffer_access_controller.sv
// Self-checking bench for buffer_access_controller (DEPTH=4): table-driven
// write/read pass plus hand sequences for wrap, underflow, arbitration and reset.
module tb_buffer_access_controller;

    localparam int DW    = 8;
    localparam int DEPTH = 4;
    localparam int AW    = $clog2(DEPTH);
    localparam logic H   = 1'b1;
    localparam logic L   = 1'b0;

    logic          clk = 1'b0;
    logic          reset;
    logic          rq_write, writing, wr_en;
    logic [DW-1:0] wr_data;
    logic          rq_read, reading, rd_en;
    logic          ack_write, ack_read;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic [AW:0]   count;
    logic          full, empty, wr_overflow, rd_underflow;

    int n_checks = 0;
    int n_fail   = 0;
    logic [DW-1:0] sb[$];

    typedef struct {
        logic          rq_w, wrg, wen;
        logic [DW-1:0] d;
        logic          push;
        logic          rq_r, rdg, ren;
        logic          ack_w, ack_r;
        logic [AW:0]   cnt;
        logic          full, empty, rvalid;
    } vec_t;

    vec_t vecs[12];

    buffer_access_controller #(
        .DATA_WIDTH(DW),
        .DEPTH     (DEPTH)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .rq_write    (rq_write),
        .writing     (writing),
        .ack_write   (ack_write),
        .wr_en       (wr_en),
        .wr_data     (wr_data),
        .rq_read     (rq_read),
        .reading     (reading),
        .ack_read    (ack_read),
        .rd_en       (rd_en),
        .rd_data     (rd_data),
        .rd_valid    (rd_valid),
        .count       (count),
        .full        (full),
        .empty       (empty),
        .wr_overflow (wr_overflow),
        .rd_underflow(rd_underflow)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, want $finish");
        $fatal(1, "watchdog");
    end

    function automatic vec_t v(input logic rq_w, wrg, wen, input logic [DW-1:0] d,
                               input logic push, input logic rq_r, rdg, ren,
                               input logic ack_w, ack_r, input logic [AW:0] cnt,
                               input logic fl, em, rv);
        vec_t r;
        r.rq_w = rq_w; r.wrg = wrg; r.wen = wen; r.d = d; r.push = push;
        r.rq_r = rq_r; r.rdg = rdg; r.ren = ren;
        r.ack_w = ack_w; r.ack_r = ack_r; r.cnt = cnt;
        r.full = fl; r.empty = em; r.rvalid = rv;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    // Advance one clock; every rd_valid pulse is matched against the scoreboard.
    task automatic step();
        logic [DW-1:0] exp;
        @(posedge clk);
        #1;
        if (rd_valid === 1'b1) begin
            n_checks++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL sb_unexpected: got rd_data=%0h, want no rd_valid", rd_data);
            end else begin
                exp = sb.pop_front();
                if (rd_data !== exp) begin
                    n_fail++;
                    $display("FAIL sb_rd_data: got %0h, want %0h", rd_data, exp);
                end else begin
                    $display("read  %0h ok", rd_data);
                end
            end
        end
    endtask

    task automatic grant_w();
        rq_write = 1'b1;
        step();
        chk("grant_w ack_write", 32'(ack_write), 32'd1);
        rq_write = 1'b0;
        writing  = 1'b1;
    endtask

    task automatic release_w();
        wr_en   = 1'b0;
        writing = 1'b0;
        step();
        chk("release_w ack_write", 32'(ack_write), 32'd0);
    endtask

    task automatic grant_r();
        rq_read = 1'b1;
        step();
        chk("grant_r ack_read", 32'(ack_read), 32'd1);
        rq_read = 1'b0;
        reading = 1'b1;
    endtask

    task automatic release_r();
        rd_en   = 1'b0;
        reading = 1'b0;
        step();
        chk("release_r ack_read", 32'(ack_read), 32'd0);
    endtask

    task automatic wr(input logic [DW-1:0] d, input logic exp_ovf);
        wr_en   = 1'b1;
        wr_data = d;
        step();
        chk("wr wr_overflow", 32'(wr_overflow), 32'(exp_ovf));
        if (!exp_ovf) sb.push_back(d);
        $display("write %0h overflow=%0b", d, wr_overflow);
    endtask

    task automatic rd(input logic exp_v, input logic exp_u);
        rd_en = 1'b1;
        step();
        chk("rd rd_valid", 32'(rd_valid), 32'(exp_v));
        chk("rd rd_underflow", 32'(rd_underflow), 32'(exp_u));
    endtask

    initial begin
        reset = 1'b1;
        rq_write = 0; writing = 0; wr_en = 0; wr_data = '0;
        rq_read = 0; reading = 0; rd_en = 0;

        // Table: writer grant, four writes filling the buffer, reader drains it.
        vecs[0]  = v(H,L,L,8'h00,L, L,L,L, H,L,3'd0,L,H,L);
        vecs[1]  = v(L,H,H,8'h10,H, L,L,L, H,L,3'd1,L,L,L);
        vecs[2]  = v(L,H,H,8'h11,H, L,L,L, H,L,3'd2,L,L,L);
        vecs[3]  = v(L,H,H,8'h12,H, L,L,L, H,L,3'd3,L,L,L);
        vecs[4]  = v(L,H,H,8'h13,H, L,L,L, H,L,3'd4,H,L,L);
        vecs[5]  = v(L,L,L,8'h00,L, L,L,L, L,L,3'd4,H,L,L);
        vecs[6]  = v(L,L,L,8'h00,L, H,L,L, L,H,3'd4,H,L,L);
        vecs[7]  = v(L,L,L,8'h00,L, L,H,H, L,H,3'd3,L,L,H);
        vecs[8]  = v(L,L,L,8'h00,L, L,H,H, L,H,3'd2,L,L,H);
        vecs[9]  = v(L,L,L,8'h00,L, L,H,H, L,H,3'd1,L,L,H);
        vecs[10] = v(L,L,L,8'h00,L, L,H,H, L,H,3'd0,L,H,H);
        vecs[11] = v(L,L,L,8'h00,L, L,L,L, L,L,3'd0,L,H,L);

        #12 reset = 1'b0;
        #1;
        chk("reset ack_write", 32'(ack_write), 32'd0);
        chk("reset ack_read", 32'(ack_read), 32'd0);
        chk("reset count", 32'(count), 32'd0);
        chk("reset empty", 32'(empty), 32'd1);
        chk("reset full", 32'(full), 32'd0);
        chk("reset rd_valid", 32'(rd_valid), 32'd0);
        chk("reset rd_data", 32'(rd_data), 32'd0);

        // Reader grant, handoff, release.
        rq_read = 1'b1;
        step();
        chk("grant ack_read", 32'(ack_read), 32'd1);
        chk("grant ack_write", 32'(ack_write), 32'd0);
        chk("grant empty", 32'(empty), 32'd1);
        chk("grant count", 32'(count), 32'd0);
        rq_read = 1'b0; reading = 1'b1;
        step();
        chk("handoff ack_read", 32'(ack_read), 32'd1);
        step();
        chk("busy ack_read", 32'(ack_read), 32'd1);
        reading = 1'b0;
        step();
        chk("release ack_read", 32'(ack_read), 32'd0);
        chk("release empty", 32'(empty), 32'd1);

        for (int i = 0; i < 12; i++) begin
            rq_write = vecs[i].rq_w; writing = vecs[i].wrg; wr_en = vecs[i].wen;
            wr_data  = vecs[i].d;
            rq_read  = vecs[i].rq_r; reading = vecs[i].rdg; rd_en = vecs[i].ren;
            if (vecs[i].push) sb.push_back(vecs[i].d);
            step();
            $display("vec %0d ack_w=%0b ack_r=%0b count=%0d full=%0b empty=%0b rv=%0b",
                     i, ack_write, ack_read, count, full, empty, rd_valid);
            chk($sformatf("vec%0d ack_write", i), 32'(ack_write), 32'(vecs[i].ack_w));
            chk($sformatf("vec%0d ack_read", i), 32'(ack_read), 32'(vecs[i].ack_r));
            chk($sformatf("vec%0d count", i), 32'(count), 32'(vecs[i].cnt));
            chk($sformatf("vec%0d full", i), 32'(full), 32'(vecs[i].full));
            chk($sformatf("vec%0d empty", i), 32'(empty), 32'(vecs[i].empty));
            chk($sformatf("vec%0d rd_valid", i), 32'(rd_valid), 32'(vecs[i].rvalid));
            chk($sformatf("vec%0d wr_overflow", i), 32'(wr_overflow), 32'd0);
            chk($sformatf("vec%0d rd_underflow", i), 32'(rd_underflow), 32'd0);
        end

        // Full and wrap: five writes (last dropped), read 2, write 2, read 4.
        grant_w();
        wr(8'h20, L); wr(8'h21, L); wr(8'h22, L); wr(8'h23, L);
        wr(8'h24, H);
        chk("full flag", 32'(full), 32'd1);
        chk("full count", 32'(count), 32'd4);
        wr_en = 1'b0;
        step();
        chk("overflow single pulse", 32'(wr_overflow), 32'd0);
        chk("full held count", 32'(count), 32'd4);
        release_w();
        grant_r();
        rd(H, L); rd(H, L);
        release_r();
        grant_w();
        wr(8'h25, L); wr(8'h26, L);
        release_w();
        grant_r();
        rd(H, L); rd(H, L); rd(H, L); rd(H, L);
        release_r();
        chk("wrap empty", 32'(empty), 32'd1);
        chk("wrap count", 32'(count), 32'd0);

        // Empty read, plus a write strobe ignored during the reader grant.
        grant_r();
        rd(L, H);
        rd_en = 1'b0; wr_en = 1'b1; wr_data = 8'h77;
        step();
        chk("underflow single pulse", 32'(rd_underflow), 32'd0);
        chk("ignored wr_en count", 32'(count), 32'd0);
        chk("ignored wr_en overflow", 32'(wr_overflow), 32'd0);
        wr_en = 1'b0;
        release_r();
        grant_w();
        wr(8'h30, L);
        release_w();
        grant_r();
        rd(H, L);
        release_r();
        chk("after underflow empty", 32'(empty), 32'd1);

        // Simultaneous requests from reset: writer first, reader after.
        #2 reset = 1'b1;
        #2 reset = 1'b0;
        rq_write = 1'b1; rq_read = 1'b1;
        step();
        chk("sim1 ack_write", 32'(ack_write), 32'd1);
        chk("sim1 ack_read", 32'(ack_read), 32'd0);
        rq_write = 1'b0; writing = 1'b1;
        step();
        chk("sim1 reader pending", 32'(ack_read), 32'd0);
        writing = 1'b0;
        step();
        chk("sim1 idle ack_write", 32'(ack_write), 32'd0);
        chk("sim1 idle ack_read", 32'(ack_read), 32'd0);
        step();
        chk("sim1 reader granted", 32'(ack_read), 32'd1);
        rq_read = 1'b0; reading = 1'b1;
        step();
        reading = 1'b0;
        step();
        chk("sim1 reader released", 32'(ack_read), 32'd0);
        grant_w();
        release_w();
        rq_write = 1'b1; rq_read = 1'b1;
        step();
        chk("sim2 ack_read", 32'(ack_read), 32'd1);
        chk("sim2 ack_write", 32'(ack_write), 32'd0);
        rq_read = 1'b0; reading = 1'b1;
        step();
        chk("sim2 writer pending", 32'(ack_write), 32'd0);
        reading = 1'b0;
        step();
        chk("sim2 reader released", 32'(ack_read), 32'd0);
        step();
        chk("sim2 writer granted", 32'(ack_write), 32'd1);
        rq_write = 1'b0;
        step();
        chk("sim2 writer released", 32'(ack_write), 32'd0);

        // Reset in the middle of a reader grant.
        grant_w();
        wr(8'h40, L); wr(8'h41, L); wr(8'h42, L); wr(8'h43, L);
        release_w();
        grant_r();
        rd(H, L); rd(H, L);
        reset = 1'b1;
        #1;
        chk("midreset ack_read", 32'(ack_read), 32'd0);
        chk("midreset count", 32'(count), 32'd0);
        chk("midreset empty", 32'(empty), 32'd1);
        chk("midreset full", 32'(full), 32'd0);
        chk("midreset rd_valid", 32'(rd_valid), 32'd0);
        sb.delete();
        #1 reset = 1'b0;
        step();
        chk("postreset rd_valid", 32'(rd_valid), 32'd0);
        chk("postreset ack_read", 32'(ack_read), 32'd0);
        step();
        chk("postreset rd_valid 2", 32'(rd_valid), 32'd0);
        rd_en = 1'b0; reading = 1'b0;
        step();

        chk("scoreboard drained", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
